// File: rtl/tlc_pkg.sv
// Shared types and defaults for the traffic-light controller (tlc) family.
// light_t  : one signal head (RED/YEL/GRN plus OFF for the dark flash half-period).
// state_t  : controller phases, including the pedestrian walk and night flash modes.
// ns_head / ew_head : decode of a phase (and flash blink) to the lamp driven on each head.
package tlc_pkg;

  typedef enum logic [1:0] {
    RED = 2'd0,
    YEL = 2'd1,
    GRN = 2'd2,
    OFF = 2'd3
  } light_t;

  typedef enum logic [2:0] {
    S_NS_G      = 3'd0,
    S_NS_Y      = 3'd1,
    S_ALL_RED_1 = 3'd2,
    S_EW_G      = 3'd3,
    S_EW_Y      = 3'd4,
    S_ALL_RED_2 = 3'd5,
    S_PED       = 3'd6,
    S_FLASH     = 3'd7
  } state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_T_GREEN_MIN = 50;
  localparam int DEF_T_GREEN_MAX = 120;
  localparam int DEF_T_YELLOW    = 10;
  localparam int DEF_T_ALLRED    = 5;
  localparam int DEF_T_WALK      = 30;
  localparam int DEF_T_FLASH     = 25;

  // NS head: flashes yellow on the lit half of the night blink.
  function automatic light_t ns_head(input state_t st, input logic blink);
    light_t l;
    case (st)
      S_NS_G:  l = GRN;
      S_NS_Y:  l = YEL;
      S_FLASH: l = blink ? OFF : YEL;
      default: l = RED;
    endcase
    return l;
  endfunction

  // EW head: shows red while NS flashes yellow, dark on the other half.
  function automatic light_t ew_head(input state_t st, input logic blink);
    light_t l;
    case (st)
      S_EW_G:  l = GRN;
      S_EW_Y:  l = YEL;
      S_FLASH: l = blink ? OFF : RED;
      default: l = RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_req_latch.sv
// Sticky request flag: set by set_i, cleared by clr_i; clear wins when both are high.
// Ports: clk, rst_n (async active-low), set_i, clr_i, flag_o (registered flag).
module tlc_req_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic set_i,
  input  logic clr_i,
  output logic flag_o
);

  logic flag_q;
  logic flag_d;

  // Next flag value with clear priority.
  always_comb begin
    flag_d = flag_q;
    if (clr_i) begin
      flag_d = 1'b0;
    end else if (set_i) begin
      flag_d = 1'b1;
    end else begin
      flag_d = flag_q;
    end
  end

  // Flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/tlc_safety_chk.sv
// Safety checker for the signal heads: never two conflicting heads moving,
// and the walk lamp only with both heads red.
// Ports: clk_i, rst_n_i, ns_light_i, ew_light_i, walk_i (all observed only).
module tlc_safety_chk
  import tlc_pkg::*;
(
  input logic   clk_i,
  input logic   rst_n_i,
  input light_t ns_light_i,
  input light_t ew_light_i,
  input logic   walk_i
);

  logic ns_go_s;
  logic ew_go_s;

  assign ns_go_s = (ns_light_i == GRN) || (ns_light_i == YEL);
  assign ew_go_s = (ew_light_i == GRN) || (ew_light_i == YEL);

  a_no_conflict: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(ns_go_s && ew_go_s));

  a_walk_all_red: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    walk_i |-> ((ns_light_i == RED) && (ew_light_i == RED)));

endmodule

// File: rtl/traffic_actuated.sv
// Vehicle-actuated two-way intersection controller with pedestrian walk phase
// and night flashing mode. Green is held while only the own approach has demand,
// and handed over after min green once the own approach gaps out, or at max green.
// Ports: clk, rst_n (async active-low); ns_car, ew_car, ped_req (detectors /
// push-button, level or pulse); flash_mode (night operation request);
// NS_light, EW_light, walk (registered lamp drives); state_o (current phase).
module traffic_actuated
  import tlc_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
  parameter int T_GREEN_MAX = DEF_T_GREEN_MAX,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_ALLRED    = DEF_T_ALLRED,
  parameter int T_WALK      = DEF_T_WALK,
  parameter int T_FLASH     = DEF_T_FLASH
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ns_car,
  input  logic   ew_car,
  input  logic   ped_req,
  input  logic   flash_mode,
  output light_t NS_light,
  output light_t EW_light,
  output logic   walk,
  output state_t state_o
);

  localparam longint CNT_LIM = 64'sd1 <<< CNT_W;

  if ((T_GREEN_MIN < 32'sd1) || (T_GREEN_MAX < 32'sd1) || (T_YELLOW < 32'sd1) ||
      (T_ALLRED < 32'sd1) || (T_WALK < 32'sd1) || (T_FLASH < 32'sd1) ||
      (T_GREEN_MIN > T_GREEN_MAX) ||
      (longint'(T_GREEN_MAX) >= CNT_LIM) || (longint'(T_YELLOW) >= CNT_LIM) ||
      (longint'(T_ALLRED) >= CNT_LIM) || (longint'(T_WALK) >= CNT_LIM) ||
      (longint'(T_FLASH) >= CNT_LIM)) begin : g_bad_params
    $error("traffic_actuated: illegal timing parameters");
  end

  // Last elapsed value of each timed interval: the phase is left at this edge.
  localparam logic [CNT_W-1:0] GMIN_END  = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_END  = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_END     = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_END    = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] WALK_END  = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] FLASH_END = CNT_W'(T_FLASH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic             blink_q, blink_d;
  light_t           ns_light_q, ew_light_q;
  logic             walk_q;

  logic ns_dem_s, ew_dem_s, ped_dem_s;
  logic ns_conflict_s, ew_conflict_s;
  logic ns_gap_s, ew_gap_s;

  // A green yields only to conflicting demand, latched or present this cycle.
  assign ns_conflict_s = ew_dem_s | ew_car | ped_dem_s | ped_req;
  assign ew_conflict_s = ns_dem_s | ns_car | ped_dem_s | ped_req;
  assign ns_gap_s = (elapsed_q >= GMIN_END) && (!ns_car || (elapsed_q >= GMAX_END));
  assign ew_gap_s = (elapsed_q >= GMIN_END) && (!ew_car || (elapsed_q >= GMAX_END));

  // Next-phase selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NS_G: begin
        if (flash_mode || (ns_conflict_s && ns_gap_s)) state_d = S_NS_Y;
        else state_d = S_NS_G;
      end
      S_NS_Y: begin
        if (elapsed_q == Y_END) state_d = S_ALL_RED_1;
        else state_d = S_NS_Y;
      end
      S_ALL_RED_1: begin
        if (elapsed_q == AR_END) state_d = flash_mode ? S_FLASH : S_EW_G;
        else state_d = S_ALL_RED_1;
      end
      S_EW_G: begin
        if (flash_mode || (ew_conflict_s && ew_gap_s)) state_d = S_EW_Y;
        else state_d = S_EW_G;
      end
      S_EW_Y: begin
        if (elapsed_q == Y_END) state_d = S_ALL_RED_2;
        else state_d = S_EW_Y;
      end
      S_ALL_RED_2: begin
        if (elapsed_q != AR_END) state_d = S_ALL_RED_2;
        else if (flash_mode) state_d = S_FLASH;
        else if (ped_dem_s) state_d = S_PED;
        else state_d = S_NS_G;
      end
      S_PED: begin
        if (elapsed_q == WALK_END) state_d = flash_mode ? S_FLASH : S_NS_G;
        else state_d = S_PED;
      end
      S_FLASH: begin
        if (!flash_mode) state_d = S_ALL_RED_2;
        else state_d = S_FLASH;
      end
      default: state_d = S_ALL_RED_2;
    endcase
  end

  // Elapsed counter and flash blink: restart on phase change, blink half-period in flash.
  always_comb begin
    elapsed_d = elapsed_q;
    blink_d   = blink_q;
    if (state_d != state_q) begin
      elapsed_d = '0;
      blink_d   = 1'b0;
    end else if ((state_q == S_FLASH) && (elapsed_q == FLASH_END)) begin
      elapsed_d = '0;
      blink_d   = ~blink_q;
    end else if (elapsed_q == {CNT_W{1'b1}}) begin
      elapsed_d = elapsed_q;
    end else begin
      elapsed_d = elapsed_q + CNT_W'(1);
    end
  end

  // Phase, counter, blink and lamp registers; lamps are decoded from the next
  // phase so they always match the registered phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_ALL_RED_2;
      elapsed_q  <= '0;
      blink_q    <= 1'b0;
      ns_light_q <= RED;
      ew_light_q <= RED;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      elapsed_q  <= elapsed_d;
      blink_q    <= blink_d;
      ns_light_q <= ns_head(state_d, blink_d);
      ew_light_q <= ew_head(state_d, blink_d);
      walk_q     <= (state_d == S_PED);
    end
  end

  // Demand latches are cleared on entry to the phase that serves them.
  tlc_req_latch u_ns_dem (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_i  (ns_car),
    .clr_i  ((state_d == S_NS_G) && (state_q != S_NS_G)),
    .flag_o (ns_dem_s)
  );

  tlc_req_latch u_ew_dem (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_i  (ew_car),
    .clr_i  ((state_d == S_EW_G) && (state_q != S_EW_G)),
    .flag_o (ew_dem_s)
  );

  tlc_req_latch u_ped_dem (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_i  (ped_req),
    .clr_i  ((state_d == S_PED) && (state_q != S_PED)),
    .flag_o (ped_dem_s)
  );

  tlc_safety_chk u_safety_chk (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .ns_light_i (ns_light_q),
    .ew_light_i (ew_light_q),
    .walk_i     (walk_q)
  );

  assign NS_light = ns_light_q;
  assign EW_light = ew_light_q;
  assign walk     = walk_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_traffic_actuated.sv
// Randomized bench for traffic_actuated against a phase/time reference model.
module tb_traffic_actuated;
  import tlc_pkg::*;

  localparam int TGMIN = 4;
  localparam int TGMAX = 8;
  localparam int TY    = 2;
  localparam int TAR   = 1;
  localparam int TW    = 3;
  localparam int TFL   = 2;

  logic   clk;
  logic   rst_n;
  logic   ns_car, ew_car, ped_req, flash_mode;
  light_t ns_l, ew_l;
  logic   walk;
  state_t st;

  traffic_actuated #(
    .CNT_W       (16),
    .T_GREEN_MIN (TGMIN),
    .T_GREEN_MAX (TGMAX),
    .T_YELLOW    (TY),
    .T_ALLRED    (TAR),
    .T_WALK      (TW),
    .T_FLASH     (TFL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ns_car     (ns_car),
    .ew_car     (ew_car),
    .ped_req    (ped_req),
    .flash_mode (flash_mode),
    .NS_light   (ns_l),
    .EW_light   (ew_l),
    .walk       (walk),
    .state_o    (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int cyc;

  // Reference model: current phase, cycles spent in it, and pending demands.
  state_t m_st;
  int     m_t;
  bit     m_ns_dem, m_ew_dem, m_ped_dem;

  task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int dwell(input state_t s);
    case (s)
      S_NS_Y, S_EW_Y:           return TY;
      S_ALL_RED_1, S_ALL_RED_2: return TAR;
      S_PED:                    return TW;
      default:                  return 0;
    endcase
  endfunction

  // Flash: lit half when the number of completed half-periods is even.
  function automatic light_t exp_ns(input state_t s, input int t);
    case (s)
      S_NS_G:  return GRN;
      S_NS_Y:  return YEL;
      S_FLASH: return (((t / TFL) % 2) == 0) ? YEL : OFF;
      default: return RED;
    endcase
  endfunction

  function automatic light_t exp_ew(input state_t s, input int t);
    case (s)
      S_EW_G:  return GRN;
      S_EW_Y:  return YEL;
      S_FLASH: return (((t / TFL) % 2) == 0) ? RED : OFF;
      default: return RED;
    endcase
  endfunction

  task automatic model_reset();
    m_st = S_ALL_RED_2;
    m_t = 0;
    m_ns_dem = 1'b0;
    m_ew_dem = 1'b0;
    m_ped_dem = 1'b0;
  endtask

  task automatic model_step(input bit ns, input bit ew, input bit ped, input bit fl);
    state_t nx;
    bit     done;
    nx = m_st;
    done = (m_t == dwell(m_st) - 1);
    case (m_st)
      S_NS_G: if (fl || ((m_ew_dem || ew || m_ped_dem || ped) && (m_t >= TGMIN - 1) &&
                         (!ns || (m_t >= TGMAX - 1)))) nx = S_NS_Y;
      S_EW_G: if (fl || ((m_ns_dem || ns || m_ped_dem || ped) && (m_t >= TGMIN - 1) &&
                         (!ew || (m_t >= TGMAX - 1)))) nx = S_EW_Y;
      S_NS_Y:      if (done) nx = S_ALL_RED_1;
      S_EW_Y:      if (done) nx = S_ALL_RED_2;
      S_ALL_RED_1: if (done) nx = fl ? S_FLASH : S_EW_G;
      S_ALL_RED_2: if (done) nx = fl ? S_FLASH : (m_ped_dem ? S_PED : S_NS_G);
      S_PED:       if (done) nx = fl ? S_FLASH : S_NS_G;
      S_FLASH:     if (!fl) nx = S_ALL_RED_2;
      default:     nx = m_st;
    endcase
    m_ns_dem  = (nx == S_NS_G && m_st != S_NS_G) ? 1'b0 : (m_ns_dem | ns);
    m_ew_dem  = (nx == S_EW_G && m_st != S_EW_G) ? 1'b0 : (m_ew_dem | ew);
    m_ped_dem = (nx == S_PED && m_st != S_PED) ? 1'b0 : (m_ped_dem | ped);
    m_t = (nx != m_st) ? 0 : m_t + 1;
    m_st = nx;
  endtask

  task automatic check_outputs(input string where);
    chk_value({where, ".state"}, st, m_st);
    chk_value({where, ".ns"}, ns_l, exp_ns(m_st, m_t));
    chk_value({where, ".ew"}, ew_l, exp_ew(m_st, m_t));
    chk_value({where, ".walk"}, walk, (m_st == S_PED));
  endtask

  // One segment of random traffic; probabilities in percent, reset in per-mille.
  task automatic run_seg(input int n, input int p_ns, input int p_ew, input int p_ped,
                         input bit ns_hold, input int p_fl, input int p_rst);
    for (int i = 0; i < n; i++) begin
      if (miscompares > 40) return;
      ns_car  = ns_hold ? 1'b1 : ($urandom_range(99) < p_ns);
      ew_car  = ($urandom_range(99) < p_ew);
      ped_req = ($urandom_range(99) < p_ped);
      if ($urandom_range(99) < p_fl) flash_mode = ~flash_mode;
      @(posedge clk);
      model_step(ns_car, ew_car, ped_req, flash_mode);
      cyc++;
      @(negedge clk);
      check_outputs("run");
      if ($urandom_range(999) < p_rst) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #1;
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    rst_n = 1'b0;
    ns_car = 1'b0;
    ew_car = 1'b0;
    ped_req = 1'b0;
    flash_mode = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;

    run_seg(40, 0, 0, 0, 1'b0, 0, 0);       // idle: NS green rests
    run_seg(600, 5, 5, 0, 1'b0, 0, 0);      // sparse vehicle pulses
    run_seg(600, 0, 6, 0, 1'b1, 0, 0);      // NS held: max-green cut-off
    run_seg(800, 10, 10, 4, 1'b0, 0, 0);    // pedestrian phases
    run_seg(1500, 20, 20, 5, 1'b0, 3, 0);   // flash entry/exit
    flash_mode = 1'b0;
    run_seg(2000, 15, 15, 6, 1'b0, 2, 6);   // mixed with resets mid-operation

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_actuated.md
Name: traffic_actuated

Overview:
- Parametrised, vehicle-actuated two-way intersection controller.
- Timings are set by parameters. Green is extended by sensor demand, limited by minimum and maximum green.
- Adds a pedestrian walk phase and a night flashing mode.
- Drives the NS and EW signal heads and the walk lamp directly. Sits at the top of the tlc design and replaces the fixed-time controller.

Parameters:
CNT_W, 16, width of the in-state elapsed counter
T_GREEN_MIN, 50, minimum green duration in cycles
T_GREEN_MAX, 120, maximum green duration in cycles when conflicting demand exists
T_YELLOW, 10, yellow duration in cycles
T_ALLRED, 5, all-red clearance duration in cycles
T_WALK, 30, pedestrian walk duration in cycles
T_FLASH, 25, half-period of the flash blink in cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
ns_car  in  1  NS vehicle detector, level or pulse
ew_car  in  1  EW vehicle detector, level or pulse
ped_req  in  1  pedestrian push-button, level or pulse
flash_mode  in  1  request for night flashing operation
NS_light  out  light_t  NS signal head
EW_light  out  light_t  EW signal head
walk  out  1  pedestrian walk lamp
state_o  out  state_t  current state, for debug and verification

Behaviour:
- States: S_NS_G, S_NS_Y, S_ALL_RED_1, S_EW_G, S_EW_Y, S_ALL_RED_2, S_PED, S_FLASH.
- Reset: state=S_ALL_RED_2, elapsed=0, all demand latches=0, blink=0.
- Outputs at reset: NS=RED, EW=RED, walk=0. The first green is therefore NS, after T_ALLRED cycles.
- Outputs are a pure decode of registered state and blink; there is no combinational path from inputs to outputs.
- Light decode:
  - NS_G: GRN/RED; NS_Y: YEL/RED.
  - EW_G: RED/GRN; EW_Y: RED/YEL.
  - ALL_RED_1, ALL_RED_2, PED: RED/RED.
  - walk=1 only in S_PED.
- elapsed:
  - Clears to 0 on every state change.
  - Otherwise increments each cycle and saturates at all-ones.
- Timed states (Y, ALL_RED, PED) last exactly T cycles; the state is left at the edge where elapsed==T-1.
- Demand latches ns_dem, ew_dem, ped_dem:
  - Set by any cycle with the corresponding input high.
  - ns_dem clears on entry to S_NS_G; ew_dem clears on entry to S_EW_G; ped_dem clears on entry to S_PED.
  - If set and clear occur in the same cycle, clear wins.
- NS green:
  - conflict = ew_dem | ew_car | ped_dem | ped_req.
  - Go to S_NS_Y when conflict is present, elapsed>=T_GREEN_MIN-1, and either ns_car=0 or elapsed>=T_GREEN_MAX-1.
  - With no conflict, rest in green indefinitely.
- EW green: symmetric, with ns_* in place of ew_*.
- Sequence:
  - NS_Y -> ALL_RED_1 -> EW_G.
  - EW_Y -> ALL_RED_2.
  - ALL_RED_2 -> S_PED if ped_dem, else NS_G.
  - PED -> NS_G.
- Flash entry:
  - flash_mode=1 in a green forces the corresponding yellow on the next edge, ignoring min green.
  - Yellow and PED always complete their full duration.
  - ALL_RED_x at expiry goes to S_FLASH while flash_mode=1. PED at expiry goes to S_FLASH.
- In S_FLASH:
  - When elapsed==T_FLASH-1, elapsed clears and blink toggles. blink is 0 on entry.
  - blink=0: NS=YEL, EW=RED. blink=1: NS=OFF, EW=OFF.
  - walk=0 throughout. Demand latches keep accumulating.
- Flash exit: flash_mode=0 in S_FLASH -> S_ALL_RED_2 on the next edge (full T_ALLRED), then the normal sequence.
- Reset mid-operation: immediately returns to the reset state; demands are lost.
- Safety invariants, checked by assertion:
  - NS and EW are never both in {GRN,YEL}.
  - walk=1 implies both heads are RED.
- Parameter legality, checked at elaboration:
  - All T>=1.
  - T_GREEN_MIN<=T_GREEN_MAX.
  - All T<2**CNT_W.

Decomposition:
- tlc_pkg:
  - light_t extended with OFF.
  - state_t extended with S_PED and S_FLASH.
  - Default timing constants.
- One sub-module: tlc_req_latch (set/clear sticky flag, clear-priority), instantiated three times.
- The elapsed counter stays inline.

Test Plan:
Common parameters: T_GREEN_MIN=4, T_GREEN_MAX=8, T_YELLOW=2, T_ALLRED=1, T_WALK=3, T_FLASH=2.
1. Reset release, no inputs -> 1 cycle RED/RED, then NS=GRN held for 30 cycles, walk=0.
2. Single-cycle ew_car pulse in cycle 1 of NS green -> NS GRN exactly 4 cycles, YEL 2, RED/RED 1, then EW GRN; ew_dem cleared on entry.
3. ns_car held high, ew_car pulse -> NS GRN exactly 8 cycles (max), then YEL.
4. ped_req pulse during NS green -> NS G 4, NS Y 2, AR 1, EW G 4, EW Y 2, AR 1, PED 3 with walk=1 and RED/RED, then NS G. No safety assertion fires.
5. flash_mode=1 in cycle 2 of NS green -> NS YEL next edge for 2 cycles, AR 1, then FLASH alternating YEL/RED and OFF/OFF every 2 cycles. flash_mode=0 -> RED/RED 1 cycle -> NS GRN.
6. rst_n low mid EW green with ped_dem set -> outputs RED/RED, walk=0 asynchronously. After release, NS G is reached without a PED phase.
